// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - two-requester round-robin arbiter in front of a shared combinational FPU
// One operation in flight: accept in IDLE, sample fpu_y in ISSUE, hold the result in RESP.
module fpu_arbiter #(
  parameter int W   = 10,
  parameter int OPW = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*W-1:0]   req_a,
  input  logic [2*W-1:0]   req_b,
  input  logic [2*OPW-1:0] req_op,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [W-1:0]     resp_data,
  output logic [W-1:0]     fpu_a,
  output logic [W-1:0]     fpu_b,
  output logic [OPW-1:0]   fpu_sel,
  input  logic [W-1:0]     fpu_y,
  output logic             busy,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_last;
  logic [W-1:0]   r_resp_data;
  logic [W-1:0]   r_fpu_a;
  logic [W-1:0]   r_fpu_b;
  logic [OPW-1:0] r_fpu_sel;
  logic [7:0]     r_op_count;
  logic           w_gnt;
  logic [1:0]     w_gnt_oh;
  logic [1:0]     w_last_oh;
  logic           w_accept;
  logic           w_issue;
  logic           w_resp_done;

  // Under contention the requester not served last wins; r_last doubles as the owner of the op in flight.
  assign w_gnt     = (req_valid == 2'b11) ? ~r_last : req_valid[1];
  assign w_gnt_oh  = w_gnt  ? 2'b10 : 2'b01;
  assign w_last_oh = r_last ? 2'b10 : 2'b01;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    req_ready   = 2'b00;
    resp_valid  = 2'b00;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_resp_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req_valid && !reset) begin
          req_ready = w_gnt_oh;
          w_accept  = 1'b1;
          w_next    = ISSUE;
        end
      end
      ISSUE: begin
        w_issue = 1'b1;
        w_next  = RESP;
      end
      RESP: begin
        resp_valid = w_last_oh;
        if (|(resp_ready & w_last_oh)) begin
          w_resp_done = 1'b1;
          w_next      = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last      <= 1'b1;
      r_resp_data <= '0;
      r_fpu_a     <= '0;
      r_fpu_b     <= '0;
      r_fpu_sel   <= '0;
      r_op_count  <= 8'd0;
    end else begin
      if (w_accept) begin
        r_last    <= w_gnt;
        r_fpu_a   <= w_gnt ? req_a[W +: W]     : req_a[0 +: W];
        r_fpu_b   <= w_gnt ? req_b[W +: W]     : req_b[0 +: W];
        r_fpu_sel <= w_gnt ? req_op[OPW +: OPW] : req_op[0 +: OPW];
      end
      if (w_issue)     r_resp_data <= fpu_y;
      if (w_resp_done) r_op_count  <= r_op_count + 8'd1;
    end
  end

  assign resp_data = r_resp_data;
  assign fpu_a     = r_fpu_a;
  assign fpu_b     = r_fpu_b;
  assign fpu_sel   = r_fpu_sel;
  assign op_count  = r_op_count;
  assign busy      = (r_state != IDLE);

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter: W, 10, operand/result width in bits.
REQ-002 Parameter: OPW, 4, operation-select width in bits.
REQ-003 Port: clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-006 Port: req_ready  output  2  per-requester accept; at most one bit high.
REQ-007 Port: req_a  input  2*W  operand A; slice [i*W +: W] belongs to requester i.
REQ-008 Port: req_b  input  2*W  operand B; same slicing as req_a.
REQ-009 Port: req_op  input  2*OPW  operation select; slice [i*OPW +: OPW] belongs to requester i.
REQ-010 Port: resp_valid  output  2  per-requester result valid; at most one bit high.
REQ-011 Port: resp_ready  input  2  per-requester result accept.
REQ-012 Port: resp_data  output  W  registered result, shared by both requesters.
REQ-013 Port: fpu_a, fpu_b  output  W each  registered operands driven to the combinational FPU.
REQ-014 Port: fpu_sel  output  OPW  registered operation select driven to the FPU.
REQ-015 Port: fpu_y  input  W  combinational FPU result.
REQ-016 Port: busy  output  1  high in any state other than IDLE.
REQ-017 Port: op_count  output  8  count of completed responses; wraps 255->0.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ISSUE, RESP.
REQ-019 IDLE: req_ready SHALL be one-hot to the granted requester when any req_valid is high, and 0 otherwise; req_ready SHALL be 0 in ISSUE and RESP.
REQ-020 Grant with one request valid: that requester. Grant with both valid: the requester not granted last; the last-grant register SHALL reset to 1, so requester 0 wins the first contention.
REQ-021 On an accept edge (req_valid[g] & req_ready[g]):
- fpu_a, fpu_b, fpu_sel SHALL load requester g's slices.
- The last-grant register SHALL load g.
- The state SHALL go to ISSUE.
REQ-022 ISSUE lasts exactly one cycle. At its closing edge, resp_data SHALL load fpu_y and the state SHALL go to RESP.
REQ-023 RESP: resp_valid[g] SHALL be 1 and the other bit 0. resp_data, fpu_a, fpu_b and fpu_sel SHALL stay stable until the response is accepted.
REQ-024 On a response-accept edge (resp_valid[g] & resp_ready[g]):
- The state SHALL return to IDLE.
- op_count SHALL increment by 1, modulo 256.
REQ-025 Latency: resp_valid SHALL rise 2 cycles after the accept edge. Minimum spacing between accepts SHALL be 3 cycles.
REQ-026 resp_ready on a non-granted bit, or outside RESP, SHALL be ignored.
REQ-027 In IDLE, fpu_a, fpu_b, fpu_sel and resp_data SHALL hold their last values.
REQ-028 A requester deasserting req_valid before acceptance SHALL not be granted. No request is queued.
REQ-029 fpu_sel SHALL be passed through unmodified; no opcode checking is performed.

Reset
REQ-030 While reset is high, and asynchronously on its assertion:
- state = IDLE, last-grant = 1.
- req_ready = 0, resp_valid = 0, busy = 0.
- resp_data, fpu_a, fpu_b, fpu_sel = 0; op_count = 0.
REQ-031 Reset asserted in ISSUE or RESP SHALL discard the in-flight operation without any response and without incrementing op_count.

Verification
REQ-032 Single op: bench FPU stub returns a+b; requester 0 sends a=10'h003, b=10'h004, op=4'h1.
-> req_ready=2'b01 the same cycle.
-> fpu_a/fpu_b/fpu_sel = 10'h003/10'h004/4'h1 the next cycle.
-> resp_valid=2'b01 with resp_data=10'h007 two cycles after accept.
-> op_count=1 after resp_ready.
REQ-033 Contention: both valid from reset.
-> requester 0 granted first.
-> with both still valid, requester 1 granted next.
-> requester 0 granted third.
REQ-034 Backpressure: resp_ready held 0 for 5 cycles in RESP.
-> resp_valid, resp_data, fpu_a, fpu_b, fpu_sel stable throughout.
-> req_ready=0 throughout.
REQ-035 Wrong-port ready: resp_ready=2'b10 while requester 0 holds the response.
-> no state change.
-> op_count unchanged.
REQ-036 Reset mid-op: reset pulsed during ISSUE.
-> all outputs at reset values immediately.
-> no resp_valid afterwards.
-> op_count=0.
REQ-037 Wrap: 256 completed ops.
-> op_count reads 0.
-> busy=0 in IDLE between ops.
